regblock_mp: RTL and testbench

//  Parametrised successor of the CPU register block: DEPTH x DW register file with
//  one write port, one tristate data-bus read port, a second registered read port

---
 rtl/regblock_mp_if.sv | 34 +++
 rtl/regblock_mp.sv | 91 +++++++++
 tb/tb_regblock_mp.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regblock_mp_if.sv
// Bus bundle for regblock_mp: write port, tristate bus read, registered port 2,
// clear control and ALU taps. The master drives requests, the slave is the register block.
interface regblock_mp_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          we;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          oe;
  logic [AW-1:0] oaddr;
  wire  [DW-1:0] odata;
  // Port 2: re2 is a request with no back-pressure; rvalid2 answers it one
  // cycle later, and rdata2 holds its last value whenever rvalid2 is low.
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic          rvalid2;
  logic          clr;
  logic          busy;
  logic [DW-1:0] rega;
  logic [DW-1:0] regb;
  logic          dbg_state;

  modport master (
    output we, iaddr, idata, oe, oaddr, re2, raddr2, clr,
    input  odata, rdata2, rvalid2, busy, rega, regb, dbg_state
  );

  modport slave (
    input  we, iaddr, idata, oe, oaddr, re2, raddr2, clr,
    output odata, rdata2, rvalid2, busy, rega, regb, dbg_state
  );
endinterface

// File: rtl/regblock_mp.sv
// DEPTH x DW register file with a write port, a tristate bus read port, a
// registered bypassing read port, ALU taps and a hardware clear sequencer.
module regblock_mp #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input logic         clk,
  input logic         rst_n,
  regblock_mp_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] regs [DEPTH];

  // The single physical write port is shared between the user write and the sweep.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_addr   = bus.iaddr;
    wr_data   = bus.idata;
    case (state)
      IDLE: begin
        wr_en = bus.we;
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt;
        wr_data = '0;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Port 2 returns what the addressed register holds after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata2  <= '0;
      bus.rvalid2 <= 1'b0;
    end else begin
      bus.rvalid2 <= bus.re2;
      if (bus.re2) begin
        if (wr_en && (wr_addr == bus.raddr2)) bus.rdata2 <= wr_data;
        else                                  bus.rdata2 <= regs[bus.raddr2];
      end
    end
  end

  assign bus.odata     = bus.oe ? regs[bus.oaddr] : {DW{1'bz}};
  assign bus.rega      = regs[0];
  assign bus.regb      = regs[1];
  assign bus.busy      = (state == CLEAR);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_regblock_mp.sv
// Bench for regblock_mp: directed vector table, model-checked random traffic,
// clear/reset corner sequences and a 16-bit / 16-entry instance.
module tb_regblock_mp;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regblock_mp_if #(.DW(DW), .AW(AW)) bus ();
  regblock_mp #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  regblock_mp_if #(.DW(16), .AW(4)) bus16 ();
  regblock_mp #(.DW(16), .AW(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: register contents plus number of sweep edges still to come.
  logic [DW-1:0] model [DEPTH];
  int            sweep_left = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd2 = '0;
  logic [DW-1:0] pre_odata;
  logic [DW-1:0] exp_pre_odata;

  typedef struct {
    logic          we;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          oe;
    logic [AW-1:0] oaddr;
    logic [DW-1:0] exp_od;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] exp_rd2;
    logic          exp_rv2;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A released bus may resolve to Z or, in a two-state simulator, to 0.
  task automatic check_hiz(input string name);
    n_checks++;
    if (!(bus.odata === {DW{1'bz}} || bus.odata === {DW{1'b0}})) begin
      n_fail++;
      $display("FAIL %s: got %h, expected z", name, bus.odata);
    end
  endtask

  function automatic void model_step(input logic we, input logic [AW-1:0] ia,
                                     input logic [DW-1:0] id, input logic clr);
    if (sweep_left > 0) begin
      model[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (we) model[ia] = id;
      if (clr) sweep_left = DEPTH;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sweep_left = 0;
    exp_q.delete();
    last_rd2 = '0;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic we, input logic [AW-1:0] ia, input logic [DW-1:0] id,
                       input logic oe, input logic [AW-1:0] oa,
                       input logic re2, input logic [AW-1:0] ra, input logic clr);
    bus.we = we; bus.iaddr = ia; bus.idata = id;
    bus.oe = oe; bus.oaddr = oa;
    bus.re2 = re2; bus.raddr2 = ra; bus.clr = clr;
    #1;
    pre_odata = bus.odata;
    exp_pre_odata = model[oa];
    @(posedge clk);
    model_step(we, ia, id, clr);
    if (re2) exp_q.push_back(model[ra]);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_port2(input logic re2);
    check("rvalid2", {31'b0, bus.rvalid2}, {31'b0, re2});
    if (re2 && exp_q.size() > 0) last_rd2 = exp_q.pop_front();
    check("rdata2", 32'(bus.rdata2), 32'(last_rd2));
  endtask

  task automatic check_state();
    check("busy", {31'b0, bus.busy}, {31'b0, sweep_left > 0});
    check("dbg_state", {31'b0, bus.dbg_state}, {31'b0, sweep_left > 0});
    check("rega", 32'(bus.rega), 32'(model[0]));
    check("regb", 32'(bus.regb), 32'(model[1]));
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, AW'(i), base + DW'(i), 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic tick16();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles;
    logic we_r, re_r, oe_r, clr_r;
    logic [AW-1:0] ia_r, oa_r, ra_r;
    logic [DW-1:0] id_r;

    bus.we = 0; bus.iaddr = '0; bus.idata = '0; bus.oe = 0; bus.oaddr = '0;
    bus.re2 = 0; bus.raddr2 = '0; bus.clr = 0;
    bus16.we = 0; bus16.iaddr = '0; bus16.idata = '0; bus16.oe = 0; bus16.oaddr = '0;
    bus16.re2 = 0; bus16.raddr2 = '0; bus16.clr = 0;
    model_reset();

    // Reset state
    #12;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_rvalid2", {31'b0, bus.rvalid2}, 32'd0);
    check("rst_rdata2", 32'(bus.rdata2), 32'd0);
    check("rst_rega", 32'(bus.rega), 32'd0);
    check("rst_regb", 32'(bus.regb), 32'd0);
    check_hiz("rst_odata_hiz");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: write, bus read, taps and port-2 bypass
    vecs[0] = '{1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'hA5, 1'b1, 3'd2, 8'hA5, 1'b1};
    vecs[2] = '{1'b1, 3'd0, 8'h3C, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 3'd1, 8'hC3, 1'b1, 3'd1, 8'h00, 1'b1, 3'd0, 8'h3C, 1'b1};
    vecs[4] = '{1'b1, 3'd5, 8'h11, 1'b1, 3'd0, 8'h3C, 1'b0, 3'd0, 8'h3C, 1'b0};
    vecs[5] = '{1'b1, 3'd5, 8'h77, 1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h77, 1'b1};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h77, 1'b1, 3'd1, 8'hC3, 1'b1};
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].we, vecs[v].iaddr, vecs[v].idata, vecs[v].oe, vecs[v].oaddr,
            vecs[v].re2, vecs[v].raddr2, 1'b0);
      if (vecs[v].oe) check($sformatf("vec%0d_odata", v), 32'(pre_odata), 32'(vecs[v].exp_od));
      check($sformatf("vec%0d_rvalid2", v), {31'b0, bus.rvalid2}, {31'b0, vecs[v].exp_rv2});
      check($sformatf("vec%0d_rdata2", v), 32'(bus.rdata2), 32'(vecs[v].exp_rd2));
      if (vecs[v].re2 && exp_q.size() > 0) last_rd2 = exp_q.pop_front();
    end
    check("tap_rega", 32'(bus.rega), 32'h3C);
    check("tap_regb", 32'(bus.regb), 32'hC3);
    bus.oe = 1'b0; bus.oaddr = 3'd2;
    #1;
    check_hiz("odata_hiz");

    // Random traffic against the model, with occasional clear pulses
    for (int n = 0; n < 300; n++) begin
      we_r = 1'($urandom_range(0, 1));  ia_r = AW'($urandom_range(0, DEPTH - 1));
      id_r = DW'($urandom);             oe_r = 1'($urandom_range(0, 1));
      oa_r = AW'($urandom_range(0, DEPTH - 1));
      re_r = 1'($urandom_range(0, 1));  ra_r = AW'($urandom_range(0, DEPTH - 1));
      clr_r = ($urandom_range(0, 24) == 0);
      drive(we_r, ia_r, id_r, oe_r, oa_r, re_r, ra_r, clr_r);
      if (oe_r) check("rnd_odata", 32'(pre_odata), 32'(exp_pre_odata));
      check_port2(re_r);
      check_state();
    end

    // Let any sweep finish, then a full clear with writes attempted while busy
    for (int k = 0; k < 4 * DEPTH && sweep_left > 0; k++) idle();
    check("idle_before_fill", {31'b0, bus.busy}, 32'd0);
    fill(8'h41);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    busy_cycles = 0;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      if (!bus.busy) break;
      busy_cycles++;
      drive(1'b1, 3'd3, 8'hFF, 1'b0, '0, 1'b1, AW'(k), 1'b0);
      check_port2(1'b1);
    end
    check("sweep_len", 32'(busy_cycles), 32'(DEPTH));
    check("busy_after_sweep", {31'b0, bus.busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.oe = 1'b1; bus.oaddr = AW'(i);
      #1;
      check($sformatf("cleared_reg%0d", i), 32'(bus.odata), 32'd0);
    end
    @(negedge clk);

    // Clear and write in the same idle cycle: the write lands, then gets swept
    drive(1'b1, 3'd1, 8'h5A, 1'b0, '0, 1'b0, '0, 1'b1);
    check("clr_we_regb", 32'(bus.regb), 32'h5A);
    for (int k = 0; k < DEPTH; k++) idle();
    check("clr_we_swept", 32'(bus.regb), 32'd0);
    check("clr_we_idle", {31'b0, bus.busy}, 32'd0);

    // Reset in the middle of a sweep takes effect without a clock edge
    fill(8'h91);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle();
    idle();
    check("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_busy", {31'b0, bus.busy}, 32'd0);
    check("async_state", {31'b0, bus.dbg_state}, 32'd0);
    check("async_rega", 32'(bus.rega), 32'd0);
    check("async_regb", 32'(bus.regb), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.oe = 1'b1; bus.oaddr = AW'(i);
      #1;
      check($sformatf("async_reg%0d", i), 32'(bus.odata), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.oe = 1'b0;

    // 16-bit data, 16 entries
    bus16.we = 1; bus16.iaddr = 4'd3; bus16.idata = 16'hBEEF;
    tick16();
    bus16.we = 0; bus16.oe = 1; bus16.oaddr = 4'd3;
    #1;
    check("w16_odata", 32'(bus16.odata), 32'hBEEF);
    bus16.we = 1; bus16.iaddr = 4'd0; bus16.idata = 16'h1234;
    tick16();
    bus16.iaddr = 4'd1; bus16.idata = 16'h5678;
    tick16();
    check("w16_rega", 32'(bus16.rega), 32'h1234);
    check("w16_regb", 32'(bus16.regb), 32'h5678);
    bus16.iaddr = 4'd7; bus16.idata = 16'h0001;
    tick16();
    bus16.iaddr = 4'd7; bus16.idata = 16'hCAFE; bus16.re2 = 1; bus16.raddr2 = 4'd7;
    bus16.oaddr = 4'd7;
    #1;
    check("w16_pre_odata", 32'(bus16.odata), 32'h0001);
    tick16();
    bus16.re2 = 0;
    check("w16_bypass", 32'(bus16.rdata2), 32'hCAFE);
    check("w16_rvalid2", {31'b0, bus16.rvalid2}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      bus16.iaddr = 4'(i); bus16.idata = 16'hB000 + 16'(i);
      tick16();
    end
    bus16.we = 0; bus16.clr = 1;
    tick16();
    bus16.clr = 0;
    busy_cycles = 0;
    for (int k = 0; k < 48; k++) begin
      if (!bus16.busy) break;
      busy_cycles++;
      tick16();
    end
    check("w16_sweep_len", 32'(busy_cycles), 32'd16);
    for (int i = 0; i < 16; i++) begin
      bus16.oaddr = 4'(i);
      #1;
      check($sformatf("w16_cleared%0d", i), 32'(bus16.odata), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
